// File: rtl/cdb_arbiter.sv
// Common data bus front end: one FIFO per producer, one registered broadcast per cycle.
// Define CDB_FIXED_PRIO_EN for fixed priority, where the lowest index wins.
// Leave it undefined for round-robin arbitration, which is the default.
module cdb_arbiter #(
    parameter int unsigned N_SRC      = 2,
    parameter int unsigned TAG_W      = 5,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned SRC_W     = $clog2(N_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_SRC-1:0]          src_valid_i,
    output logic [N_SRC-1:0]          src_ready_o,
    input  logic [N_SRC*TAG_W-1:0]    src_tag_i,
    input  logic [N_SRC*DATA_W-1:0]   src_data_i,
    output logic                      cdb_valid_o,
    output logic [TAG_W-1:0]          cdb_tag_o,
    output logic [DATA_W-1:0]         cdb_data_o,
    output logic [SRC_W-1:0]          cdb_src_o
);

    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned ENT_W = TAG_W + DATA_W;

    logic [ENT_W-1:0]  mem_q    [N_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [N_SRC];
    logic [PTR_W-1:0]  wr_ptr_d [N_SRC];
    logic [PTR_W-1:0]  rd_ptr_q [N_SRC];
    logic [PTR_W-1:0]  rd_ptr_d [N_SRC];
    logic [N_SRC-1:0]  empty;
    logic [N_SRC-1:0]  full;
    logic [N_SRC-1:0]  push;
    logic              grant_valid;
    logic [SRC_W-1:0]  grant_idx;
    logic [ENT_W-1:0]  pop_ent;
    logic [IDX_W-1:0]  pop_idx;

    logic              cdb_valid_q;
    logic [TAG_W-1:0]  cdb_tag_q;
    logic [DATA_W-1:0] cdb_data_q;
    logic [SRC_W-1:0]  cdb_src_q;
`ifndef CDB_FIXED_PRIO_EN
    logic [SRC_W-1:0]  last_grant_q;
    int unsigned       cand;
`endif

    // FIFO status from registered pointers; the MSB is the wrap bit
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]  = (wr_ptr_q[i][PTR_W-1] != rd_ptr_q[i][PTR_W-1]) &&
                       (wr_ptr_q[i][IDX_W-1:0] == rd_ptr_q[i][IDX_W-1:0]);
        end
    end

    assign src_ready_o = ~full & ~{N_SRC{rst}};
    assign push        = src_valid_i & src_ready_o;

    // Pick one non-empty FIFO to broadcast this cycle
    always_comb begin
        grant_valid = |(~empty);
        grant_idx   = '0;
`ifdef CDB_FIXED_PRIO_EN
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (!empty[i]) grant_idx = SRC_W'(i);
        end
`else
        cand = 0;
        // Walk from the farthest candidate back so the nearest one after last_grant wins
        for (int k = N_SRC - 1; k >= 0; k--) begin
            cand = (32'(last_grant_q) + 32'(k) + 32'd1) % N_SRC;
            if (!empty[SRC_W'(cand)]) grant_idx = SRC_W'(cand);
        end
`endif
    end

    // Read the head entry of the winning FIFO
    always_comb begin
        pop_idx = rd_ptr_q[grant_idx][IDX_W-1:0];
        pop_ent = mem_q[grant_idx][pop_idx];
    end

    // Next pointer values; they wrap modulo 2*FIFO_DEPTH
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(grant_valid && (grant_idx == SRC_W'(i)));
        end
    end

    // FIFO storage; it needs no reset because the pointers gate every read
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i][IDX_W-1:0]] <= {src_tag_i[i*TAG_W +: TAG_W],
                                                      src_data_i[i*DATA_W +: DATA_W]};
            end
        end
    end

    // Pointers, the broadcast register and the arbitration state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
`ifndef CDB_FIXED_PRIO_EN
            last_grant_q <= SRC_W'(N_SRC - 1);
`endif
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
            cdb_valid_q <= grant_valid;
            if (grant_valid) begin
                cdb_tag_q  <= pop_ent[ENT_W-1:DATA_W];
                cdb_data_q <= pop_ent[DATA_W-1:0];
                cdb_src_q  <= grant_idx;
`ifndef CDB_FIXED_PRIO_EN
                last_grant_q <= grant_idx;
`endif
            end
        end
    end

    assign cdb_valid_o = cdb_valid_q;
    assign cdb_tag_o   = cdb_tag_q;
    assign cdb_data_o  = cdb_data_q;
    assign cdb_src_o   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter (N_SRC=2, FIFO_DEPTH=4).
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  src_valid;
    logic [1:0]  src_ready;
    logic [9:0]  src_tag;
    logic [63:0] src_data;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_src;

    typedef struct packed {
        logic [4:0]  tag;
        logic [31:0] data;
    } ent_t;

    ent_t sb0[$];
    ent_t sb1[$];
    int   exp_src[$];
    int   errors = 0;
    int   checks = 0;
    int   accepted = 0;
    int   bcasts = 0;
    int   saw_nr = 0;
    ent_t mon_e;
    int   mon_s;

    always #5 clk = ~clk;

    cdb_arbiter #(.N_SRC(2), .TAG_W(5), .DATA_W(32), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid_i (src_valid),
        .src_ready_o (src_ready),
        .src_tag_i   (src_tag),
        .src_data_i  (src_data),
        .cdb_valid_o (cdb_valid),
        .cdb_tag_o   (cdb_tag),
        .cdb_data_o  (cdb_data),
        .cdb_src_o   (cdb_src)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and record accepted pushes
    task automatic drive(input logic [1:0] v, input logic [4:0] t0, input logic [31:0] d0,
                         input logic [4:0] t1, input logic [31:0] d1);
        @(negedge clk);
        src_valid = v;
        src_tag   = {t1, t0};
        src_data  = {d1, d0};
        if (src_ready != 2'b11) saw_nr = 1;
        if (v[0] && src_ready[0]) begin sb0.push_back({t0, d0}); accepted++; end
        if (v[1] && src_ready[1]) begin sb1.push_back({t1, d1}); accepted++; end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    endtask

    // Monitor: every broadcast must match the head of its source's expected queue
    always @(negedge clk) begin
        if (!rst && cdb_valid) begin
            bcasts++;
            if (cdb_src == 1'b0) begin
                if (sb0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_bcast src0: got tag %0h, none expected", cdb_tag);
                end else begin
                    mon_e = sb0.pop_front();
                    check("bcast_src0", 64'({cdb_tag, cdb_data}), 64'(mon_e));
                end
            end else begin
                if (sb1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_bcast src1: got tag %0h, none expected", cdb_tag);
                end else begin
                    mon_e = sb1.pop_front();
                    check("bcast_src1", 64'({cdb_tag, cdb_data}), 64'(mon_e));
                end
            end
            if (exp_src.size() != 0) begin
                mon_s = exp_src.pop_front();
                check("grant_order", 64'(cdb_src), 64'(mon_s));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        src_valid = 2'b00;
        src_tag   = '0;
        src_data  = '0;

        // Reset behaviour
        repeat (2) @(negedge clk);
        check("rst_cdb_valid", 64'(cdb_valid), 64'(0));
        check("rst_src_ready", 64'(src_ready), 64'(0));
        rst = 1'b0;
        #1;
        check("rel_src_ready", 64'(src_ready), 64'(3));
        @(negedge clk);
        check("rel_cdb_valid", 64'(cdb_valid), 64'(0));

        // Single push: no bypass, one-cycle pulse, outputs hold afterwards
        drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        check("single_no_bypass", 64'(cdb_valid), 64'(0));
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        check("single_valid", 64'(cdb_valid), 64'(1));
        check("single_src", 64'(cdb_src), 64'(0));
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        check("single_one_cycle", 64'(cdb_valid), 64'(0));
        check("idle_tag_hold", 64'(cdb_tag), 64'(5));
        check("idle_data_hold", 64'(cdb_data), 64'(32'hDEADBEEF));

        // Contention: both sources push six times
`ifdef CDB_FIXED_PRIO_EN
        for (int i = 0; i < 6; i++) exp_src.push_back(0);
        for (int i = 0; i < 4; i++) exp_src.push_back(1);
`else
        for (int i = 0; i < 6; i++) begin exp_src.push_back(1); exp_src.push_back(0); end
`endif
        for (int c = 0; c < 6; c++)
            drive(2'b11, 5'(c), 32'h1000_0000 + 32'(c), 5'(16 + c), 32'h2000_0000 + 32'(c));
        idle(16);
        check("contention_order_done", 64'(exp_src.size()), 64'(0));
        check("contention_drained", 64'(sb0.size() + sb1.size()), 64'(0));

        // Backpressure: continuous pushes must fill a FIFO without losing entries
        saw_nr = 0;
        for (int c = 0; c < 14; c++)
            drive(2'b11, 5'(c), 32'hA000_0000 + 32'(c), 5'(31 - c), 32'hB000_0000 + 32'(c));
        idle(24);
        check("bp_ready_dropped", 64'(saw_nr), 64'(1));
        check("bp_drained", 64'(sb0.size() + sb1.size()), 64'(0));
        check("bp_no_loss", 64'(bcasts), 64'(accepted));

        // Mid-stream reset: held entries are discarded
        for (int c = 0; c < 3; c++)
            drive(2'b11, 5'(20 + c), 32'hC000_0000 + 32'(c), 5'(24 + c), 32'hD000_0000 + 32'(c));
        @(negedge clk);
        src_valid = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_cdb_valid", 64'(cdb_valid), 64'(0));
        check("midrst_src_ready", 64'(src_ready), 64'(0));
        sb0.delete();
        sb1.delete();
        exp_src.delete();
        accepted = 0;
        bcasts   = 0;
        @(negedge clk);
        rst = 1'b0;
        idle(10);
        check("midrst_no_stale", 64'(bcasts), 64'(0));

        // After reset the block works normally again
        exp_src.push_back(1);
        drive(2'b10, 5'd0, 32'd0, 5'd9, 32'h1234_5678);
        idle(5);
        check("post_rst_drained", 64'(sb0.size() + sb1.size() + exp_src.size()), 64'(0));
        check("post_rst_count", 64'(bcasts), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
